mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences and shares the single main_memory port between instruction fetch (read-only)
//  and data access (read/write). Models a fixed multi-cycle memory latency and round-robin
//  arbitrates the two requesters. Drives main_memory addr/data_to_write/wrt_en and returns
//  captured read data with a one-cycle ack. Sits between the fetch/LSU stages and main_memory.
// PARAMETERS
//  ADDR_W   20  address width (= MEM_ADDRESS_LEN)
//  DATA_W   32  data width (= MEM_DATA_WIDTH)
//  LATENCY  5   cycles each access occupies memory; legal range 1..15
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  if_req      in   1       fetch read request, level, held until if_ack
//  if_addr     in   ADDR_W  fetch address
//  if_rdata    out  DATA_W  fetch read data, valid with if_ack, held until next if_ack
//  if_ack      out  1       one-cycle completion pulse to fetch
//  d_req       in   1       data request, level, held until d_ack
//  d_wr        in   1       1 = write, 0 = read
//  d_addr      in   ADDR_W  data address
//  d_wdata     in   DATA_W  write data
//  d_rdata     out  DATA_W  data read data, valid with d_ack, held until next d_ack
//  d_ack       out  1       one-cycle completion pulse to data side
//  mem_addr    out  ADDR_W  to main_memory addr
//  mem_wdata   out  DATA_W  to main_memory data_to_write
//  mem_wrt_en  out  1       to main_memory wrt_en
//  mem_rdata   in   DATA_W  from main_memory data_to_read
//  busy        out  1       1 while state != IDLE
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE, last_grant=DATA, cnt=0; all outputs 0.
//  Reset mid-transaction drops it: no ack and no wrt_en pulse; requester reissues.
//  States: IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: no req -> stay. One req -> grant it. Both -> grant port != last_grant.
//    On grant: latch port id, addr, wr (fetch wr=0), wdata; cnt=LATENCY-1; -> BUSY.
//  BUSY: mem_addr/mem_wdata driven from latches (registered, stable all of BUSY).
//    cnt!=0 -> cnt-1. cnt==0: write -> mem_wrt_en=1 this cycle only;
//    read -> capture mem_rdata into granted port's rdata reg; -> RESP.
//  RESP: granted ack=1 for exactly one cycle; last_grant=granted; -> IDLE.
//  Latency: req seen in IDLE cycle T -> ack in cycle T+LATENCY+1; next grant earliest T+LATENCY+2.
//  Requester drops or re-requests the edge after ack; IDLE re-samples then, so no double service.
//  mem_wrt_en is never 1 outside the last BUSY cycle; mem_addr/mem_wdata hold after RESP.
//  if_ack and d_ack are never 1 in the same cycle. Sustained dual req strictly alternates.
//  req dropped before ack: violation; transaction still completes (write committed), ack sent.
//  No alignment/range check: address passes unchanged; caller keeps addr+3 in range.
//  rdata of the non-granted port and rdata after a write are unchanged.
// TESTING
//  1 LATENCY=5, mem[0..3]=word 0x00000002: if_req, if_addr=0 at T -> if_ack at T+6, if_rdata=0x00000002.
//  2 d write 0xDEADBEEF @0x100 -> one wrt_en pulse in last BUSY cycle; read @0x100 -> d_rdata=0xDEADBEEF.
//  3 if_req,d_req both rise in T out of reset -> IF granted first (ack T+6), data ack T+13.
//  4 Both held across 3 transactions each -> acks alternate IF,D,IF,D,IF,D; never coincident.
//  5 reset=0 during BUSY of write @0x40 -> no wrt_en, no ack, busy=0, mem[0x40] unchanged.
//  6 LATENCY=1: single d read -> ack at T+2; back-to-back d reads -> acks every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch (read-only) and data access
// for a single main_memory port, with a fixed multi-cycle access latency.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wrt_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter reload: the access spans LATENCY cycles, counting down to zero.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_r;
  logic        last_grant_r;  // 1 = data port served last
  logic        grant_r;       // 1 = data port owns the current access
  logic        wr_r;
  logic [3:0]  cnt_r;
  logic        grant_d_s;

  // Pick the requester to serve: alternate when both ask, else whoever asks.
  always_comb begin
    grant_d_s = 1'b0;
    if (if_req && d_req) begin
      grant_d_s = ~last_grant_r;
    end else if (d_req) begin
      grant_d_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
  end

  // Access sequencer: IDLE -> BUSY (LATENCY cycles) -> RESP -> IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      wr_r         <= 1'b0;
      cnt_r        <= 4'd0;
      if_rdata     <= '0;
      if_ack       <= 1'b0;
      d_rdata      <= '0;
      d_ack        <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wrt_en   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      mem_wrt_en <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (if_req || d_req) begin
            grant_r  <= grant_d_s;
            wr_r     <= grant_d_s & d_wr;
            mem_addr <= grant_d_s ? d_addr : if_addr;
            if (grant_d_s) begin
              mem_wdata <= d_wdata;
            end
            cnt_r <= CNT_INIT;
            // A one-cycle access is already in its last cycle once granted.
            mem_wrt_en <= (CNT_INIT == 4'd0) && grant_d_s && d_wr;
            busy       <= 1'b1;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r      <= cnt_r - 4'd1;
            mem_wrt_en <= (cnt_r == 4'd1) && wr_r;
          end else begin
            if (!wr_r) begin
              if (grant_r) begin
                d_rdata <= mem_rdata;
              end else begin
                if_rdata <= mem_rdata;
              end
            end
            if (grant_r) begin
              d_ack <= 1'b1;
            end else begin
              if_ack <= 1'b1;
            end
            state_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          last_grant_r <= grant_r;
          busy         <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LATENCY=5 instance and a LATENCY=1 instance,
// each with a behavioural memory and an ack scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // LATENCY=5 instance
  logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [19:0] if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [19:0] mem_addr;
  logic        if_ack, d_ack, mem_wrt_en, busy;

  // LATENCY=1 instance
  logic        if1_req = 1'b0, d1_req = 1'b0, d1_wr = 1'b0;
  logic [19:0] if1_addr = '0, d1_addr = '0;
  logic [31:0] d1_wdata = '0;
  logic [31:0] if1_rdata, d1_rdata, mem1_wdata, mem1_rdata;
  logic [19:0] mem1_addr;
  logic        if1_ack, d1_ack, mem1_wrt_en, busy1;

  mem_arbiter #(.ADDR_W(20), .DATA_W(32), .LATENCY(5)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wrt_en(mem_wrt_en),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(20), .DATA_W(32), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ack(if1_ack),
    .d_req(d1_req), .d_wr(d1_wr), .d_addr(d1_addr), .d_wdata(d1_wdata),
    .d_rdata(d1_rdata), .d_ack(d1_ack),
    .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_wrt_en(mem1_wrt_en),
    .mem_rdata(mem1_rdata), .busy(busy1)
  );

  // Behavioural memories with a backdoor preload port
  logic [31:0] mem  [0:4095];
  logic [31:0] mem1 [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign mem_rdata  = mem[mem_addr[11:0]];
  assign mem1_rdata = mem1[mem1_addr[11:0]];

  always @(posedge clk) begin
    if (mem_wrt_en) mem[mem_addr[11:0]] <= mem_wdata;
    else if (pre_en) mem[pre_addr] <= pre_data;
    if (mem1_wrt_en) mem1[mem1_addr[11:0]] <= mem1_wdata;
    else if (pre_en) mem1[pre_addr] <= pre_data;
  end

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic [31:0] m0_if = '0, m0_d = '0, m1_if = '0, m1_d = '0;
  int          wr_pulses = 0;
  int          wr_cyc = -1;

  // Scoreboard for the LATENCY=5 instance
  always @(negedge clk) begin
    if (mem_wrt_en) begin
      wr_pulses++;
      wr_cyc = cyc;
    end
    if (!reset) begin
      m0_if = '0;
      m0_d  = '0;
    end
    if (if_ack || d_ack) begin
      n_cmp++;
      assert (!(if_ack && d_ack)) else begin
        n_bad++; $error("FAIL ack_overlap0: observed both acks, expected one");
      end
      n_cmp++;
      assert (q0.size() > 0) else begin
        n_bad++; $error("FAIL unexp_ack0: observed ack at cyc %0d, expected none", cyc);
      end
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        if (!e0.wr) begin
          if (e0.is_d) m0_d = e0.data;
          else m0_if = e0.data;
        end
        n_cmp++;
        assert (d_ack === e0.is_d) else begin
          n_bad++; $error("FAIL port0: observed d_ack=%0b expected %0b", d_ack, e0.is_d);
        end
        n_cmp++;
        assert (cyc === e0.cyc) else begin
          n_bad++; $error("FAIL ack_cyc0: observed %0d expected %0d", cyc, e0.cyc);
        end
        n_cmp++;
        assert (if_rdata === m0_if) else begin
          n_bad++; $error("FAIL if_rdata0: observed %08h expected %08h", if_rdata, m0_if);
        end
        n_cmp++;
        assert (d_rdata === m0_d) else begin
          n_bad++; $error("FAIL d_rdata0: observed %08h expected %08h", d_rdata, m0_d);
        end
      end
    end
  end

  // Scoreboard for the LATENCY=1 instance
  always @(negedge clk) begin
    if (if1_ack || d1_ack) begin
      n_cmp++;
      assert (q1.size() > 0) else begin
        n_bad++; $error("FAIL unexp_ack1: observed ack at cyc %0d, expected none", cyc);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        if (!e1.wr) begin
          if (e1.is_d) m1_d = e1.data;
          else m1_if = e1.data;
        end
        n_cmp++;
        assert (d1_ack === e1.is_d && cyc === e1.cyc) else begin
          n_bad++; $error("FAIL ack1: observed d_ack=%0b cyc=%0d expected d_ack=%0b cyc=%0d",
                          d1_ack, cyc, e1.is_d, e1.cyc);
        end
        n_cmp++;
        assert (d1_rdata === m1_d) else begin
          n_bad++; $error("FAIL d_rdata1: observed %08h expected %08h", d1_rdata, m1_d);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++; $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] dat);
    @(negedge clk);
    pre_addr = a;
    pre_data = dat;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  task automatic wait_ack(input bit which, output int at_cyc);
    int found;
    found = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (which ? (if1_ack || d1_ack) : (if_ack || d_ack)) begin
        found = cyc;
        break;
      end
    end
    at_cyc = found;
    n_cmp++;
    assert (found >= 0) else begin
      n_bad++; $error("FAIL ack_timeout: observed no ack in 60 cycles, expected ack");
    end
  endtask

  function automatic exp_t mk(input logic is_d, input logic wr, input logic [31:0] dat,
                              input int c);
    exp_t e;
    e.is_d = is_d;
    e.wr   = wr;
    e.data = dat;
    e.cyc  = c;
    return e;
  endfunction

  initial begin
    int c, a, base;
    preload(12'h000, 32'h0000_0002);
    preload(12'h040, 32'hA5A5_A5A5);
    preload(12'h010, 32'h1000_00A0);
    preload(12'h011, 32'h1000_00A1);
    preload(12'h012, 32'h1000_00A2);
    preload(12'h013, 32'h1000_00A3);

    // Reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acks", 64'({if_ack, d_ack, mem_wrt_en}), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fetch read at address 0
    c = cyc;
    if_req = 1'b1; if_addr = 20'h0;
    q0.push_back(mk(1'b0, 1'b0, 32'h0000_0002, c + 6));
    @(negedge clk);
    chk("busy_on", 64'(busy), 64'd1);
    wait_ack(1'b0, a);
    if_req = 1'b0;
    @(negedge clk);
    chk("busy_off", 64'(busy), 64'd0);

    // Data write then read-back at 0x100
    c = cyc;
    base = wr_pulses;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 20'h100; d_wdata = 32'hDEAD_BEEF;
    q0.push_back(mk(1'b1, 1'b1, 32'h0, c + 6));
    wait_ack(1'b0, a);
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    chk("wr_pulses", 64'(wr_pulses - base), 64'd1);
    chk("wr_cyc", 64'(wr_cyc), 64'(c + 5));
    chk("mem_100", 64'(mem[12'h100]), 64'hDEAD_BEEF);
    c = cyc;
    d_req = 1'b1; d_addr = 20'h100;
    q0.push_back(mk(1'b1, 1'b0, 32'hDEAD_BEEF, c + 6));
    wait_ack(1'b0, a);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("addr_hold", 64'(mem_addr), 64'h100);

    // Reset in the middle of a write to 0x40
    c = cyc;
    base = wr_pulses;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 20'h040; d_wdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    d_req = 1'b0; d_wr = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_outs", 64'({if_ack, d_ack, mem_wrt_en}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_wr", 64'(wr_pulses - base), 64'd0);
    chk("mem_40", 64'(mem[12'h040]), 64'hA5A5_A5A5);

    // Both requesters held from reset: IF first, then strict alternation
    c = cyc;
    if_req = 1'b1; if_addr = 20'h0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 20'h100;
    for (int k = 0; k < 6; k++) begin
      q0.push_back(mk(k[0], 1'b0, k[0] ? 32'hDEAD_BEEF : 32'h0000_0002, c + 6 + 7 * k));
    end
    for (int k = 0; k < 6; k++) begin
      wait_ack(1'b0, a);
      if (k == 4) if_req = 1'b0;
      if (k == 5) d_req = 1'b0;
    end
    @(negedge clk);

    // LATENCY=1: single read, then back-to-back reads every 3 cycles
    c = cyc;
    d1_req = 1'b1; d1_addr = 20'h010;
    q1.push_back(mk(1'b1, 1'b0, 32'h1000_00A0, c + 2));
    wait_ack(1'b1, a);
    d1_req = 1'b0;
    @(negedge clk);
    c = cyc;
    d1_req = 1'b1; d1_addr = 20'h011;
    for (int k = 0; k < 3; k++) begin
      q1.push_back(mk(1'b1, 1'b0, 32'h1000_00A1 + 32'(k), c + 2 + 3 * k));
    end
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, a);
      if (k < 2) d1_addr = 20'h012 + 20'(k);
      else d1_req = 1'b0;
    end
    repeat (3) @(negedge clk);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
